wb_arb_rr: RTL and testbench

Round-robin arbiter sharing one Wishbone-style slave bus between N requesting masters, single clock domain. Sits between several local bus masters (CPU, DMA, debug bridge) and a single downstream port such as an `xclk_wb` crossing or a peripheral bank. It serialises transactions, routes address, data and ack, and aborts transactions the slave never acknowledges using a watchdog.

---
 rtl/wb_arb_rr.sv | 120 ++++++++++++
 tb/tb_wb_arb_rr.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arb_rr.sv
// Round-robin arbiter that shares one Wishbone-style slave port between N masters.
// A watchdog aborts transactions the slave never acknowledges.
module wb_arb_rr #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 16,
  parameter int unsigned AW = 16,
  parameter int unsigned TW = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N*AW-1:0] s_addr,
  input  logic [N*DW-1:0] s_wdata,
  output logic [N*DW-1:0] s_rdata,
  input  logic [N-1:0]    s_cyc,
  input  logic [N-1:0]    s_we,
  output logic [N-1:0]    s_ack,
  output logic [AW-1:0]   m_addr,
  output logic [DW-1:0]   m_wdata,
  input  logic [DW-1:0]   m_rdata,
  output logic            m_cyc,
  output logic            m_we,
  input  logic            m_ack,
  output logic            timeout
);

  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic {
    StIdle,
    StBusy
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] grant_q, grant_d;
  logic [IW-1:0] last_q, last_d;
  logic [TW-1:0] cnt_q, cnt_d;

  logic          found;
  logic [IW-1:0] pick;
  logic [IW-1:0] cand;

  // Scan last+1, last+2, ... modulo N; the first requester wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    cand  = '0;
    for (int unsigned k = 1; k <= N; k++) begin
      cand = IW'((32'(last_q) + k) % N);
      if (!found && s_cyc[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    s_rdata = '0;
    s_ack   = '0;
    m_addr  = '0;
    m_wdata = '0;
    m_cyc   = 1'b0;
    m_we    = 1'b0;
    timeout = 1'b0;

    case (state_q)
      StIdle: begin
        // Any m_ack arriving here is a late ack from an aborted slave and is dropped.
        if (found) begin
          grant_d = pick;
          last_d  = pick;
          cnt_d   = '0;
          state_d = StBusy;
        end
      end

      StBusy: begin
        m_cyc   = 1'b1;
        m_addr  = s_addr[grant_q*AW +: AW];
        m_wdata = s_wdata[grant_q*DW +: DW];
        m_we    = s_we[grant_q];
        cnt_d   = cnt_q + TW'(1);

        if (!s_cyc[grant_q]) begin
          state_d = StIdle;
        end else if (m_ack) begin
          s_ack[grant_q]               = 1'b1;
          s_rdata[grant_q*DW +: DW]    = m_rdata;
          state_d                      = StIdle;
        end else if (cnt_q == {TW{1'b1}}) begin
          // Dropping m_cyc next cycle is what aborts the slave side.
          s_ack[grant_q]               = 1'b1;
          s_rdata[grant_q*DW +: DW]    = {DW{1'b1}};
          timeout                      = 1'b1;
          state_d                      = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      grant_q <= '0;
      last_q  <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_wb_arb_rr.sv
// Directed bench for wb_arb_rr: grant latency, round-robin order, back-to-back fairness,
// watchdog abort, master abort and reset during a transaction.
module tb_wb_arb_rr;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 16;
  localparam int unsigned AW = 16;
  localparam int unsigned TW = 4;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N*AW-1:0] s_addr;
  logic [N*DW-1:0] s_wdata;
  logic [N*DW-1:0] s_rdata;
  logic [N-1:0]    s_cyc;
  logic [N-1:0]    s_we;
  logic [N-1:0]    s_ack;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic [DW-1:0]   m_rdata;
  logic            m_cyc;
  logic            m_we;
  logic            m_ack;
  logic            timeout;

  int checks   = 0;
  int failures = 0;

  wb_arb_rr #(
    .N (N),
    .DW(DW),
    .AW(AW),
    .TW(TW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .s_addr (s_addr),
    .s_wdata(s_wdata),
    .s_rdata(s_rdata),
    .s_cyc  (s_cyc),
    .s_we   (s_we),
    .s_ack  (s_ack),
    .m_addr (m_addr),
    .m_wdata(m_wdata),
    .m_rdata(m_rdata),
    .m_cyc  (m_cyc),
    .m_we   (m_we),
    .m_ack  (m_ack),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  // Advance past the next rising edge; inputs are then changed well away from it.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    s_cyc   = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    settle();
    checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL reset_m_cyc got=%h exp=0", m_cyc); end
    checks++; if (m_addr !== '0 || m_wdata !== '0 || m_we !== 1'b0) begin
      failures++; $display("FAIL reset_m_bus got=%h/%h/%h exp=0", m_addr, m_wdata, m_we); end
    checks++; if (s_ack !== '0 || s_rdata !== '0 || timeout !== 1'b0) begin
      failures++; $display("FAIL reset_s_side got=%h/%h/%h exp=0", s_ack, s_rdata, timeout); end
  endtask

  task automatic test_single_master();
    do_reset();
    s_cyc = 4'b0100;
    settle();
    checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL single_latency got=%h exp=0", m_cyc); end
    cyc();
    settle();
    checks++; if (m_cyc !== 1'b1 || m_addr !== 16'hA002 || m_we !== 1'b0 || m_wdata !== 16'hD002) begin
      failures++; $display("FAIL single_grant got=%h/%h/%h/%h exp=1/a002/0/d002", m_cyc, m_addr, m_we, m_wdata); end
    cyc();
    cyc();
    settle();
    checks++; if (s_ack !== 4'b0000) begin failures++; $display("FAIL single_early_ack got=%h exp=0", s_ack); end
    cyc();
    m_ack   = 1'b1;
    m_rdata = 16'hBEEF;
    settle();
    checks++; if (s_ack !== 4'b0100) begin failures++; $display("FAIL single_ack got=%h exp=4", s_ack); end
    checks++; if (s_rdata !== 64'h0000_BEEF_0000_0000) begin
      failures++; $display("FAIL single_rdata got=%h exp=0000beef00000000", s_rdata); end
    cyc();
    s_cyc   = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
    settle();
    checks++; if (m_cyc !== 1'b0 || s_ack !== '0) begin
      failures++; $display("FAIL single_release got=%h/%h exp=0/0", m_cyc, s_ack); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_ack;
    rst_n   = 1'b0;
    s_cyc   = 4'b1111;
    m_ack   = 1'b1;
    m_rdata = 16'h5A5A;
    cyc();
    cyc();
    rst_n = 1'b1;
    settle();
    checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL rr_idle_after_reset got=%h exp=0", m_cyc); end
    for (int i = 0; i < 6; i++) begin
      exp_ack = 4'b0001 << (i % 4);
      cyc();
      settle();
      checks++; if (m_cyc !== 1'b1 || s_ack !== exp_ack || m_addr !== 16'hA000 + 16'(i % 4)) begin
        failures++; $display("FAIL rr_grant%0d got=%h/%h/%h exp=1/%h/%h", i, m_cyc, s_ack, m_addr,
                             exp_ack, 16'hA000 + 16'(i % 4)); end
      cyc();
      settle();
      checks++; if (m_cyc !== 1'b0 || s_ack !== '0) begin
        failures++; $display("FAIL rr_gap%0d got=%h/%h exp=0/0", i, m_cyc, s_ack); end
    end
    s_cyc = '0;
    m_ack = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    s_cyc = 4'b0010;
    cyc();
    m_ack = 1'b1;
    s_cyc = 4'b1010;
    settle();
    checks++; if (s_ack !== 4'b0010 || m_we !== 1'b1) begin
      failures++; $display("FAIL b2b_first got=%h/%h exp=2/1", s_ack, m_we); end
    cyc();
    settle();
    checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL b2b_gap got=%h exp=0", m_cyc); end
    cyc();
    settle();
    checks++; if (s_ack !== 4'b1000 || m_addr !== 16'hA003) begin
      failures++; $display("FAIL b2b_fair got=%h/%h exp=8/a003", s_ack, m_addr); end
    cyc();
    s_cyc = 4'b0010;
    cyc();
    settle();
    checks++; if (s_ack !== 4'b0010 || m_addr !== 16'hA001) begin
      failures++; $display("FAIL b2b_second got=%h/%h exp=2/a001", s_ack, m_addr); end
    cyc();
    s_cyc = '0;
    m_ack = 1'b0;
  endtask

  task automatic test_watchdog();
    do_reset();
    s_cyc = 4'b0010;
    cyc();
    for (int i = 1; i < 16; i++) begin
      settle();
      checks++; if (m_cyc !== 1'b1 || timeout !== 1'b0 || s_ack !== '0) begin
        failures++; $display("FAIL wd_wait%0d got=%h/%h/%h exp=1/0/0", i, m_cyc, timeout, s_ack); end
      cyc();
    end
    settle();
    checks++; if (timeout !== 1'b1 || s_ack !== 4'b0010) begin
      failures++; $display("FAIL wd_fire got=%h/%h exp=1/2", timeout, s_ack); end
    checks++; if (s_rdata !== 64'h0000_0000_FFFF_0000) begin
      failures++; $display("FAIL wd_rdata got=%h exp=00000000ffff0000", s_rdata); end
    cyc();
    s_cyc = '0;
    m_ack = 1'b1;
    settle();
    checks++; if (m_cyc !== 1'b0 || timeout !== 1'b0 || s_ack !== '0) begin
      failures++; $display("FAIL wd_late_ack got=%h/%h/%h exp=0/0/0", m_cyc, timeout, s_ack); end
    cyc();
    m_ack = 1'b0;
  endtask

  task automatic test_abort_and_reset();
    do_reset();
    s_cyc = 4'b0100;
    cyc();
    cyc();
    s_cyc = 4'b0000;
    m_ack = 1'b1;
    settle();
    checks++; if (s_ack !== '0 || s_rdata !== '0) begin
      failures++; $display("FAIL abort_no_ack got=%h/%h exp=0/0", s_ack, s_rdata); end
    cyc();
    m_ack = 1'b0;
    settle();
    checks++; if (m_cyc !== 1'b0) begin failures++; $display("FAIL abort_release got=%h exp=0", m_cyc); end

    s_cyc = 4'b1000;
    cyc();
    settle();
    checks++; if (m_cyc !== 1'b1 || m_addr !== 16'hA003) begin
      failures++; $display("FAIL rst_busy got=%h/%h exp=1/a003", m_cyc, m_addr); end
    rst_n = 1'b0;
    s_cyc = 4'b1001;
    cyc();
    settle();
    checks++; if (m_cyc !== 1'b0 || m_addr !== '0 || m_wdata !== '0 || m_we !== 1'b0 ||
                  s_ack !== '0 || s_rdata !== '0 || timeout !== 1'b0) begin
      failures++; $display("FAIL rst_outputs got=%h/%h/%h/%h/%h/%h/%h exp=0", m_cyc, m_addr, m_wdata,
                           m_we, s_ack, s_rdata, timeout); end
    rst_n = 1'b1;
    cyc();
    settle();
    checks++; if (m_cyc !== 1'b1 || m_addr !== 16'hA000) begin
      failures++; $display("FAIL rst_regrant got=%h/%h exp=1/a000", m_cyc, m_addr); end
    cyc();
    s_cyc = '0;
  endtask

  initial begin
    rst_n   = 1'b0;
    s_addr  = {16'hA003, 16'hA002, 16'hA001, 16'hA000};
    s_wdata = {16'hD003, 16'hD002, 16'hD001, 16'hD000};
    s_we    = 4'b1010;
    s_cyc   = '0;
    m_ack   = 1'b0;
    m_rdata = '0;
    test_reset();
    test_single_master();
    test_round_robin();
    test_back_to_back();
    test_watchdog();
    test_abort_and_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
